dti_monitor: RTL
================

// Module: dti_monitor
// PURPOSE
//  Synthesizable, multi-channel passive monitor for DTI valid/ready/data links.
//  Snoops N_CH channels without driving them.
//  Checks protocol rules: valid held until handshake, data stable while stalled, stall timeout.
//  Keeps sticky error flags plus saturating transfer/stall counters for debug readout.
//  Sits beside any producer/consumer pair, in silicon or in the testbench.
// PARAMETERS
//  W_DATA   64    data width of each monitored channel
//  N_CH     1     number of monitored channels (>=1)
//  TIMEOUT  1024  stall cycles (valid & !ready) before err_timeout; 0 disables check
//  W_CNT    32    width of each transfer/stall counter
// PORTS
//  clk          in   1             single clock; all logic rising-edge
//  rst          in   1             synchronous, active-high reset
//  enable       in   1             1 = checks and counters active
//  clear        in   1             1-cycle pulse: clears error flags and counters
//  mon_data     in   N_CH*W_DATA   snooped data, channel i at [i*W_DATA +: W_DATA]
//  mon_valid    in   N_CH          snooped valid
//  mon_ready    in   N_CH          snooped ready
//  err_hold     out  N_CH          sticky: valid dropped before handshake
//  err_stable   out  N_CH          sticky: data changed while stalled
//  err_timeout  out  N_CH          sticky: stall reached TIMEOUT cycles
//  err_any      out  1             OR of all error bits, registered
//  pending      out  N_CH          channel holds an unacknowledged valid (state != IDLE)
//  xfer_cnt     out  N_CH*W_CNT    handshakes seen (valid & ready), saturating
//  stall_cnt    out  N_CH*W_CNT    cycles with valid & !ready, saturating
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - all outputs 0, all channel FSMs IDLE, history registers 0.
//   - Reset mid-transfer discards the pending state; no error is raised for it.
//  Per-channel FSM; inputs are sampled on each posedge:
//   - IDLE: v&!r -> PEND, capture data, wait_cnt=1. Otherwise stay IDLE.
//   - PEND:
//       v&r -> IDLE.
//       !v -> IDLE, set err_hold.
//       v&!r & data!=captured -> stay PEND, set err_stable, recapture data.
//       wait_cnt==TIMEOUT-1 -> EXPIRED, set err_timeout.
//       Otherwise wait_cnt++.
//   - EXPIRED:
//       Same hold/stable checks as PEND.
//       v&r or !v -> IDLE.
//       No further timeout flags until the channel returns to IDLE.
//   - TIMEOUT=0: PEND never moves to EXPIRED.
//   - Events are not exclusive: stable and timeout violations in the same cycle set both flags.
//  Latency:
//   - Error flags, counters and pending are registered.
//   - They are visible 1 cycle after the sampling edge of the offending cycle.
//   - err_any follows the error flags 1 cycle later (2 cycles after the event).
//  Counters:
//   - xfer_cnt += 1 on each v&r; stall_cnt += 1 on each v&!r.
//   - Both saturate at 2**W_CNT-1 and never wrap.
//  enable=0:
//   - FSMs still track state (so re-enabling mid-stall gives no false err_hold).
//   - Flags and counters hold their values; no new errors are set.
//  clear=1:
//   - Zeroes flags and counters.
//   - Clear wins over same-cycle events; the event is not recorded.
//   - FSM state and wait_cnt are unaffected.
//  Flags are sticky until clear or rst. Channels are fully independent; no cross-channel state.
// STRUCTURE
//  Package dti_pkg:
//   - typedef enum logic [1:0] {IDLE, PEND, EXPIRED} dti_mon_state_e
//   - typedef struct packed {hold, stable, timeout} dti_mon_err_t
//   - function sat_inc()
//  Sub-module dti_monitor_ch holds one channel: FSM, data capture, wait counter, counters.
//  Top-level dti_monitor has a generate loop over N_CH, the err_any OR-reduce and output packing.
//  Wait counter width is $clog2(TIMEOUT+1), minimum 1.
// TESTING
//  1) N_CH=2; ch0 v&r for 10 cycles, ch1 idle -> xfer_cnt[0]=10, xfer_cnt[1]=0, no errors.
//  2) ch0 v=1, r=0 for 3 cycles, then v=0 -> err_hold[0]=1 the cycle after the drop; stall_cnt[0]=3.
//  3) ch0 stalled, data 0xAA -> 0xBB mid-stall -> err_stable[0]=1; err_any=1 one cycle later.
//  4) TIMEOUT=8; stall 20 cycles, then r=1 -> err_timeout=1 after the 8th stall sample, set once; pending=0 after handshake.
//  5) W_CNT=4; 20 handshakes -> xfer_cnt=15 (saturated). clear pulse coincident with a violation -> all 0, no flag.
//  6) rst asserted mid-stall -> all outputs 0 next cycle; v=0 afterwards raises no err_hold.

Source files
------------

// File: rtl/dti_pkg.sv
// -----------------------------------------------------------------------------
// dti_pkg
//   Shared types and helpers for the DTI valid/ready link monitor.
//   - dti_mon_state_e : per-channel protocol tracking state
//   - dti_mon_err_t   : one-cycle violation events / sticky flag bundle
//   - sat_inc()       : saturating increment for counters up to SAT_W bits wide
// -----------------------------------------------------------------------------
package dti_pkg;

  // Widest counter the saturating helper can service.
  localparam int unsigned SAT_W = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PEND    = 2'd1,
    EXPIRED = 2'd2
  } dti_mon_state_e;

  typedef struct packed {
    logic hold;
    logic stable;
    logic timeout;
  } dti_mon_err_t;

  // Increment value, clamping at 2**width-1. The caller widens its counter
  // to SAT_W bits on the way in and truncates back on the way out.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] value,
                                               input int unsigned      width);
    logic [SAT_W-1:0] max_val;
    if (width >= SAT_W) begin
      max_val = '1;
    end else begin
      max_val = (SAT_W'(1) << width) - SAT_W'(1);
    end
    if (value >= max_val) begin
      return max_val;
    end
    return value + SAT_W'(1);
  endfunction

endpackage

// File: rtl/dti_monitor_ch.sv
// -----------------------------------------------------------------------------
// dti_monitor_ch
//   Passive monitor for a single valid/ready/data link. Tracks the handshake
//   with a small FSM, captures the stalled data word, counts stall cycles
//   against TIMEOUT and keeps sticky error flags plus saturating counters.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   enable       1 = record errors and count; FSM tracks regardless
//   clear        zero flags and counters (wins over same-cycle events)
//   data         snooped data word
//   valid        snooped valid
//   ready        snooped ready
//   err_hold     sticky: valid dropped before handshake
//   err_stable   sticky: data changed while stalled
//   err_timeout  sticky: stall reached TIMEOUT cycles
//   pending      FSM is not IDLE (unacknowledged valid outstanding)
//   xfer_cnt     saturating count of valid & ready cycles
//   stall_cnt    saturating count of valid & !ready cycles
// -----------------------------------------------------------------------------
module dti_monitor_ch
  import dti_pkg::*;
#(
  parameter int W_DATA  = 64,
  parameter int TIMEOUT = 1024,
  parameter int W_CNT   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              clear,
  input  logic [W_DATA-1:0] data,
  input  logic              valid,
  input  logic              ready,
  output logic              err_hold,
  output logic              err_stable,
  output logic              err_timeout,
  output logic              pending,
  output logic [W_CNT-1:0]  xfer_cnt,
  output logic [W_CNT-1:0]  stall_cnt
);

  localparam bit TIMEOUT_EN = (TIMEOUT > 0);
  localparam int W_WAIT     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  // wait_cnt holds (stall samples seen - 1); reaching TIMEOUT-1 on a fresh
  // stall sample means this sample is the TIMEOUT-th one.
  localparam logic [W_WAIT-1:0] WAIT_LAST = TIMEOUT_EN ? W_WAIT'(TIMEOUT - 1) : '0;

  dti_mon_state_e    state_q, state_d;
  logic [W_WAIT-1:0] wait_q, wait_d;
  logic [W_DATA-1:0] cap_q, cap_d;
  dti_mon_err_t      ev;
  dti_mon_err_t      err_q;
  logic              xfer;
  logic              stall;

  assign xfer  = valid & ready;
  assign stall = valid & ~ready;

  // Next-state and violation detection. Stable and timeout checks are
  // evaluated independently so one stall sample can raise both.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    cap_d   = cap_q;
    ev      = '0;

    case (state_q)
      IDLE: begin
        if (stall) begin
          state_d = PEND;
          cap_d   = data;
          wait_d  = W_WAIT'(1);
        end
      end

      PEND, EXPIRED: begin
        if (!valid) begin
          state_d = IDLE;
          ev.hold = 1'b1;
        end else if (ready) begin
          state_d = IDLE;
        end else begin
          if (data != cap_q) begin
            ev.stable = 1'b1;
            cap_d     = data;
          end
          // EXPIRED never re-arms the timeout until the channel goes IDLE.
          if (TIMEOUT_EN && (state_q == PEND)) begin
            if (wait_q >= WAIT_LAST) begin
              state_d    = EXPIRED;
              ev.timeout = 1'b1;
            end else begin
              wait_d = wait_q + 1'b1;
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wait_q  <= '0;
      cap_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cap_q   <= cap_d;
    end
  end

  // Flags and counters freeze while disabled; clear shares the reset path
  // so an event in the clear cycle is dropped.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      err_q     <= '0;
      xfer_cnt  <= '0;
      stall_cnt <= '0;
    end else if (enable) begin
      err_q.hold    <= err_q.hold    | ev.hold;
      err_q.stable  <= err_q.stable  | ev.stable;
      err_q.timeout <= err_q.timeout | ev.timeout;
      if (xfer) begin
        xfer_cnt <= W_CNT'(sat_inc(SAT_W'(xfer_cnt), W_CNT));
      end
      if (stall) begin
        stall_cnt <= W_CNT'(sat_inc(SAT_W'(stall_cnt), W_CNT));
      end
    end
  end

  assign err_hold    = err_q.hold;
  assign err_stable  = err_q.stable;
  assign err_timeout = err_q.timeout;
  assign pending     = (state_q != IDLE);

endmodule

// File: rtl/dti_monitor.sv
// -----------------------------------------------------------------------------
// dti_monitor
//   Multi-channel passive monitor for DTI valid/ready/data links. One
//   dti_monitor_ch per channel; this level packs the per-channel results and
//   registers a global error summary.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   enable       1 = checks and counters active
//   clear        1-cycle pulse clearing flags and counters
//   mon_data     N_CH*W_DATA snooped data, channel i at [i*W_DATA +: W_DATA]
//   mon_valid    N_CH snooped valid
//   mon_ready    N_CH snooped ready
//   err_hold     N_CH sticky valid-dropped flags
//   err_stable   N_CH sticky data-changed-while-stalled flags
//   err_timeout  N_CH sticky stall-timeout flags
//   err_any      registered OR of every error flag
//   pending      N_CH channel holds an unacknowledged valid
//   xfer_cnt     N_CH*W_CNT saturating handshake counters
//   stall_cnt    N_CH*W_CNT saturating stall counters
// -----------------------------------------------------------------------------
module dti_monitor
  import dti_pkg::*;
#(
  parameter int W_DATA  = 64,
  parameter int N_CH    = 1,
  parameter int TIMEOUT = 1024,
  parameter int W_CNT   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   clear,
  input  logic [N_CH*W_DATA-1:0] mon_data,
  input  logic [N_CH-1:0]        mon_valid,
  input  logic [N_CH-1:0]        mon_ready,
  output logic [N_CH-1:0]        err_hold,
  output logic [N_CH-1:0]        err_stable,
  output logic [N_CH-1:0]        err_timeout,
  output logic                   err_any,
  output logic [N_CH-1:0]        pending,
  output logic [N_CH*W_CNT-1:0]  xfer_cnt,
  output logic [N_CH*W_CNT-1:0]  stall_cnt
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    dti_monitor_ch #(
      .W_DATA  (W_DATA),
      .TIMEOUT (TIMEOUT),
      .W_CNT   (W_CNT)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .clear       (clear),
      .data        (mon_data[i*W_DATA +: W_DATA]),
      .valid       (mon_valid[i]),
      .ready       (mon_ready[i]),
      .err_hold    (err_hold[i]),
      .err_stable  (err_stable[i]),
      .err_timeout (err_timeout[i]),
      .pending     (pending[i]),
      .xfer_cnt    (xfer_cnt[i*W_CNT +: W_CNT]),
      .stall_cnt   (stall_cnt[i*W_CNT +: W_CNT])
    );
  end

  // Built from the registered flags, so it trails them by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_any <= 1'b0;
    end else begin
      err_any <= (|err_hold) | (|err_stable) | (|err_timeout);
    end
  end

endmodule
